// File: rtl/trapezoid_fill.sv
// Column-major rasteriser for one vertically-edged quadrilateral (maze wall/floor slab).
// Both slanted edges are stepped with Bresenham error accumulators; no multiply or divide.
module trapezoid_fill #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic signed [CORDW-1:0] x2,
  input  logic signed [CORDW-1:0] y2,
  input  logic signed [CORDW-1:0] x3,
  input  logic signed [CORDW-1:0] y3,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, INIT, EDGE, EMIT, NEXT, DONE} state_t;
  state_t state, state_nxt;

  localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

  // One bit wider than the coordinates so differences of extreme vertices cannot wrap.
  function automatic logic signed [CORDW:0] wide_sub(input logic signed [CORDW-1:0] a,
                                                     input logic signed [CORDW-1:0] b);
    return $signed({a[CORDW-1], a}) - $signed({b[CORDW-1], b});
  endfunction

  function automatic logic [CORDW:0] mag(input logic signed [CORDW:0] v);
    return v[CORDW] ? $unsigned(-v) : $unsigned(v);
  endfunction

  logic signed [CORDW-1:0] vx0, vx1, vy0, vy1, vy2, vy3;
  logic        [CORDW:0]   dx, dyt_abs, dyb_abs, err_t, err_b;
  logic                    sgn_t, sgn_b;
  logic signed [CORDW-1:0] c, yt, yb, row;
  logic signed [CORDW:0]   dt_w, db_w;
  logic                    need_t, need_b;

  // x2/x3 only duplicate x1/x0 for a vertical-edged quad.
  logic unused_ok;
  assign unused_ok = ^{x2, x3};

  assign dt_w   = wide_sub(vy1, vy0);
  assign db_w   = wide_sub(vy2, vy3);
  assign need_t = (dx != '0) && (err_t >= dx);
  assign need_b = (dx != '0) && (err_b >= dx);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = INIT;
      INIT: state_nxt = EDGE;
      EDGE: if (!need_t && !need_b) state_nxt = (yt > yb) ? NEXT : EMIT;
      EMIT: if (oe && row == yb) state_nxt = NEXT;
      NEXT: state_nxt = (c == vx1) ? DONE : EDGE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        vx0 <= x0; vx1 <= x1;
        vy0 <= y0; vy1 <= y1; vy2 <= y2; vy3 <= y3;
      end
      INIT: begin
        dx      <= $unsigned(wide_sub(vx1, vx0));
        dyt_abs <= mag(dt_w);
        dyb_abs <= mag(db_w);
        sgn_t   <= dt_w[CORDW];
        sgn_b   <= db_w[CORDW];
        c       <= vx0;
        yt      <= vy0;
        yb      <= vy3;
        err_t   <= '0;
        err_b   <= '0;
      end
      // One edge correction per cycle, top edge first.
      EDGE: begin
        if (need_t) begin
          yt    <= sgn_t ? yt - ONE : yt + ONE;
          err_t <= err_t - dx;
        end else if (need_b) begin
          yb    <= sgn_b ? yb - ONE : yb + ONE;
          err_b <= err_b - dx;
        end else begin
          row <= yt;
        end
      end
      EMIT: if (oe && row != yb) row <= row + ONE;
      NEXT: if (c != vx1) begin
        c     <= c + ONE;
        err_t <= err_t + dyt_abs;
        err_b <= err_b + dyb_abs;
      end
      default: ;
    endcase
  end

  // Pixel output is registered: a pixel accepted in EMIT appears the following cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      x       <= '0;
      y       <= '0;
      drawing <= 1'b0;
    end else begin
      drawing <= (state == EMIT) && oe;
      if (state == EMIT && oe) begin
        x <= c;
        y <= row;
      end
    end
  end

endmodule

// File: tb/tb_trapezoid_fill.sv
// Scoreboard bench for trapezoid_fill: directed fills, oe stalls, degenerate shapes, control.
module tb_trapezoid_fill;
  localparam int CORDW = 16;

  logic clk = 1'b0;
  logic rstn, start, oe;
  logic signed [CORDW-1:0] x0, y0, x1, y1, x2, y2, x3, y3, x, y;
  logic drawing, busy, done;

  trapezoid_fill #(.CORDW(CORDW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .oe(oe),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_done; int px; int py; } item_t;
  item_t sbq[$];

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, pix_cnt = 0, first_pix_cyc = -1, last_pix_cyc = 0;
  int last_x = 0, last_y = 0, start_cyc = 0;
  bit armed = 1'b0, rst_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations as the DUT presents output.
  always @(negedge clk) begin
    item_t it;
    if (rst_prev) begin
      chk("reset_busy", int'(busy), 0);
      chk("reset_drawing", int'(drawing), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_x", int'(x), 0);
      chk("reset_y", int'(y), 0);
      sbq.delete();
      last_x = 0; last_y = 0; armed = 1'b1;
    end else if (armed) begin
      if (drawing) begin
        checks++;
        if (sbq.size() == 0 || sbq[0].is_done) begin
          errors++;
          $display("FAIL pixel_unexpected: got (%0d,%0d), expected no pixel", int'(x), int'(y));
        end else begin
          it = sbq.pop_front();
          chk("pixel_x", int'(x), it.px);
          chk("pixel_y", int'(y), it.py);
          last_x = it.px; last_y = it.py;
        end
        pix_cnt++;
        if (first_pix_cyc < 0) first_pix_cyc = cyc;
        last_pix_cyc = cyc;
      end else begin
        chk("hold_x", int'(x), last_x);
        chk("hold_y", int'(y), last_y);
      end
      if (done) begin
        checks++;
        if (sbq.size() == 0 || !sbq[0].is_done) begin
          errors++;
          $display("FAIL done_unexpected: got done=1 with %0d items pending, expected done after all pixels", sbq.size());
        end else begin
          void'(sbq.pop_front());
        end
        done_cnt++;
        done_cyc = cyc;
      end
    end
    rst_prev = !rstn;
  end

  task automatic push_golden(input int ax0, ay0, ax1, ay1, ay2, ay3);
    int dx, yt, yb;
    item_t it;
    dx = ax1 - ax0;
    for (int c = ax0; c <= ax1; c++) begin
      yt = (dx == 0) ? ay0 : ay0 + ((c - ax0) * (ay1 - ay0)) / dx;
      yb = (dx == 0) ? ay3 : ay3 + ((c - ax0) * (ay2 - ay3)) / dx;
      for (int yy = yt; yy <= yb; yy++) begin
        it.is_done = 1'b0; it.px = c; it.py = yy;
        sbq.push_back(it);
      end
    end
    it.is_done = 1'b1; it.px = 0; it.py = 0;
    sbq.push_back(it);
  endtask

  task automatic scramble();
    x0 = CORDW'($urandom); y0 = CORDW'($urandom); x1 = CORDW'($urandom); y1 = CORDW'($urandom);
    x2 = CORDW'($urandom); y2 = CORDW'($urandom); x3 = CORDW'($urandom); y3 = CORDW'($urandom);
  endtask

  // Returns at the falling edge of the cycle after start was sampled.
  task automatic launch(input int ax0, ay0, ax1, ay1, ay2, ay3);
    push_golden(ax0, ay0, ax1, ay1, ay2, ay3);
    x0 = CORDW'(ax0); y0 = CORDW'(ay0); x1 = CORDW'(ax1); y1 = CORDW'(ay1);
    x2 = CORDW'(ax1); y2 = CORDW'(ay2); x3 = CORDW'(ax0); y3 = CORDW'(ay3);
    first_pix_cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
    scramble();
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); n++;
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one done pulse", budget);
    end else begin
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("queue_drained", sbq.size(), 0);
    end
  endtask

  task automatic stall_rect();
    logic [31:0] pat;
    int ph, left, col, stalls, k, p0;
    bit o;
    pat = 32'b1001_1010_0110_0011_1001_0101_1100_1001;
    p0 = pix_cnt;
    launch(0, 0, 3, 0, 2, 2);
    ph = 0; left = 0; col = 0; stalls = 0; k = 0;
    while (ph != 4 && k < 200) begin
      o = pat[k % 32];
      oe = o;
      @(posedge clk); #1;
      case (ph)
        0: ph = 1;
        1: begin ph = 2; left = 3; end
        2: if (o) begin left--; if (left == 0) ph = 3; end else stalls++;
        3: if (col == 3) ph = 4; else begin col++; ph = 1; end
        default: ;
      endcase
      k++;
    end
    oe = 1'b1;
    wait_done(100);
    chk("stall_done_latency", done_cyc - start_cyc, 21 + stalls);
    chk("stall_pixel_count", pix_cnt - p0, 12);
  endtask

  initial begin
    int p0, d0;
    rstn = 1'b0; start = 1'b0; oe = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Rectangle: 12 pixels, 3-cycle latency, done 21 cycles after start.
    p0 = pix_cnt;
    launch(0, 0, 3, 0, 2, 2);
    wait_done(100);
    chk("rect_first_latency", first_pix_cyc - start_cyc, 3);
    chk("rect_done_latency", done_cyc - start_cyc, 21);
    chk("rect_pixel_count", pix_cnt - p0, 12);

    // Left-wall trapezoid: 9+9+7+7+5 pixels.
    p0 = pix_cnt;
    launch(0, 0, 4, 2, 6, 8);
    wait_done(200);
    chk("trap_pixel_count", pix_cnt - p0, 37);

    stall_rect();

    // Single column.
    p0 = pix_cnt;
    launch(5, 3, 5, 3, 6, 6);
    wait_done(100);
    chk("dx0_pixel_count", pix_cnt - p0, 4);

    // Steep edges: column 1 needs many corrections before (1,10).
    p0 = pix_cnt;
    launch(0, 0, 1, 10, 10, 0);
    wait_done(200);
    chk("steep_pixel_count", pix_cnt - p0, 2);
    chk("steep_gap_ge13", int'(last_pix_cyc - first_pix_cyc >= 13), 1);

    // Every column inverted: nothing drawn, done still pulses.
    p0 = pix_cnt; d0 = done_cnt;
    launch(0, 5, 2, 5, 1, 1);
    wait_done(100);
    chk("inverted_pixel_count", pix_cnt - p0, 0);
    chk("inverted_done_count", done_cnt - d0, 1);

    // Start re-asserted mid-fill with other vertices is ignored.
    p0 = pix_cnt;
    launch(0, 0, 4, 2, 6, 8);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    x0 = 16'sd10; y0 = 16'sd10; x1 = 16'sd20; y1 = 16'sd20;
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    wait_done(200);
    chk("restart_pixel_count", pix_cnt - p0, 37);

    // Reset mid-EMIT: outputs cleared, no done pulse.
    p0 = pix_cnt; d0 = done_cnt;
    launch(0, 0, 3, 0, 2, 2);
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("reset_no_done", done_cnt - d0, 0);
    chk("reset_partial_pixels", pix_cnt - p0, 2);
    chk("reset_idle_busy", int'(busy), 0);

    // Fresh fill after reset.
    p0 = pix_cnt;
    launch(0, 0, 3, 0, 2, 2);
    wait_done(100);
    chk("fresh_first_latency", first_pix_cyc - start_cyc, 3);
    chk("fresh_pixel_count", pix_cnt - p0, 12);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/trapezoid_fill.md
Name: trapezoid_fill

Overview:
- Rasterises one filled, vertically-edged quadrilateral (a wall, floor or ceiling slab of the maze view) into a stream of pixel coordinates.
- Sits directly downstream of the maze view-building FSM. That FSM loads four vertices, pulses start, and waits for done.
- The pixel stream (x, y, drawing) feeds the framebuffer write port.
- Fill order is column-major: left to right, and top to bottom within each column.

Parameters:
- CORDW, 16, signed coordinate width of every vertex and output coordinate.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, reset, synchronous, active-low.
- start, in, 1, latch vertices and begin fill; honoured only in IDLE.
- oe, in, 1, output enable; 0 stalls pixel advance.
- x0, y0, in, CORDW signed each, top-left vertex.
- x1, y1, in, CORDW signed each, top-right vertex.
- x2, y2, in, CORDW signed each, bottom-right vertex.
- x3, y3, in, CORDW signed each, bottom-left vertex.
- x, y, out, CORDW signed each, current pixel.
- drawing, out, 1, x/y is a valid pixel this cycle.
- busy, out, 1, fill in progress.
- done, out, 1, one-cycle pulse on completion.

Behaviour:
- Clock and reset: clk; reset rstn, synchronous, active-low. Reset is honoured in any state, including mid-fill.
- Reset values: state=IDLE, x=0, y=0, drawing=0, busy=0, done=0. Any in-progress fill is abandoned, with no done pulse.
- Preconditions (caller's responsibility): x0==x3, x1==x2, x0<=x1. Behaviour is unspecified otherwise.
- Start handling: on start in IDLE, all eight vertices are registered. Later input changes are ignored. start while busy is ignored.
- Fill definition. Let DX = x1-x0. For each column c from x0 to x1 inclusive:
  - ytop(c) = y0 + trunc((c-x0)*(y1-y0)/DX)
  - ybot(c) = y3 + trunc((c-x0)*(y2-y3)/DX)
  - trunc rounds toward zero.
  - If DX==0: one column, with ytop=y0 and ybot=y3.
- Emission: pixels (c, ytop..ybot) are emitted in ascending y. A column with ytop>ybot emits nothing, but the fill continues.
- Arithmetic: incremental Bresenham, with no multiplier or divider.
  - Each edge keeps a y register, an error accumulator of width CORDW+1 in range [0, DX), |dy| and a sign.
  - On column advance: err += |dy|. Then, while err >= DX: y += sign and err -= DX, one correction per cycle.
- FSM:
  - IDLE: busy=0. On start go to INIT.
  - INIT (1 cycle): compute DX, |dy| and sign for both edges. Set c=x0 and both edge y registers to y0/y3. Go to EDGE.
  - EDGE: perform one top or bottom correction per cycle until both errors are < DX, then load row=ytop. Go to EMIT, or go to NEXT if ytop>ybot. The first column needs no correction and takes exactly 1 cycle.
  - EMIT: drawing=oe, x=c, y=row.
    - When oe=1: if row==ybot go to NEXT; otherwise row++.
    - When oe=0: hold x/y and stay in EMIT, with drawing=0.
  - NEXT (1 cycle): if c==x1 go to DONE. Otherwise c++, add |dy| to both errors, and go to EDGE.
  - DONE (1 cycle): done=1 and busy=1, then IDLE. start in this cycle is ignored.
- busy: goes high the cycle after start is sampled and stays high through the DONE cycle.
- Latency: the first drawing=1 occurs 3 clocks after the start-sampling edge (INIT, EDGE, EMIT), given oe=1.
- Throughput: 1 pixel per clock within a column.
- Per-column overhead: 1 NEXT cycle, 1 EDGE cycle, plus the steep-edge correction cycles.
- drawing never asserts outside EMIT.
- x and y hold their last value when drawing=0.

Test Plan:
- Rectangle: (0,0),(3,0),(3,2),(0,2) with oe=1.
  - Expect 12 pixels in order (0,0),(0,1),(0,2),(1,0),...,(3,2).
  - First pixel 3 cycles after start.
  - One done pulse, then busy=0.
- Left-wall trapezoid: (0,0),(4,2),(4,6),(0,8).
  - Expected per-column ranges: x=0 y0..8; x=1 y0..8; x=2 y1..7; x=3 y1..7; x=4 y2..6.
  - 37 pixels total, exact order checked against the golden model.
- oe stall: the rectangle fill with oe toggled 1,0,0,1 in a pseudo-random pattern.
  - Same 12 pixels, no duplicates and none skipped.
  - x/y hold during oe=0.
  - done is delayed by exactly the number of stall cycles.
- Degenerate cases:
  - DX=0, (5,3),(5,3),(5,6),(5,6): 4 pixels, x=5, y=3..6.
  - Steep edge (0,0),(1,10),(1,10),(0,0): column 0 emits only (0,0), and column 1 takes ≥10 EDGE correction cycles before emitting (1,10).
  - Inverted columns emit nothing while done still pulses.
- Control: start is re-asserted mid-fill with different vertices.
  - The re-assertion is ignored and the original fill completes unchanged.
  - rstn is pulled low mid-EMIT: next cycle busy=0, drawing=0, x=y=0, no done pulse.
  - A new start after reset behaves as a fresh fill.
